// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: stall vector, flush strobe,
// redirect PC and post-flush drain FSM. Optional watchdog: PIPE_STALL_WATCHDOG_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned WDOG_LIMIT   = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] cp0_epc_i,
    output logic [3:0]  stall_o,
    output logic        flush,
    output logic [31:0] new_pc_o,
    output logic [1:0]  ctrl_state_o,
    output logic        wdog_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    localparam logic [31:0] EXC_ERET   = 32'h0000000E;
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_drain_cnt;
    logic [3:0]  w_drain_cnt_next;
    logic        w_any_req;
    logic        w_exc_valid;
    logic [3:0]  w_req_vec;

    assign w_any_req   = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
    assign w_exc_valid = (exception_type_i != 32'h0) && (r_state != ST_DRAIN);

    // Highest requesting stage freezes itself and every stage behind it.
    always_comb begin
        w_req_vec = 4'b0000;
        if (stallreq_mem)
            w_req_vec = 4'b1111;
        else if (stallreq_ex)
            w_req_vec = 4'b0111;
        else if (stallreq_id)
            w_req_vec = 4'b0011;
        else if (stallreq_if)
            w_req_vec = 4'b0001;
    end

    always_comb begin
        stall_o  = 4'b0000;
        flush    = 1'b0;
        new_pc_o = 32'h0;
        if (resetn) begin
            if (w_exc_valid) begin
                flush    = 1'b1;
                new_pc_o = (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else begin
                stall_o = w_req_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_exc_valid) begin
                    w_state_next     = ST_DRAIN;
                    w_drain_cnt_next = DRAIN_LOAD;
                end else if (w_any_req) begin
                    w_state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (w_exc_valid) begin
                    w_state_next     = ST_DRAIN;
                    w_drain_cnt_next = DRAIN_LOAD;
                end else if (!w_any_req) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Countdown keeps running even while stages are stalled.
                if (r_drain_cnt == 4'd0)
                    w_state_next = ST_RUN;
                else
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
            end
            default: begin
                w_state_next     = ST_RUN;
                w_drain_cnt_next = 4'd0;
            end
        endcase
    end

    assign ctrl_state_o = r_state;

`ifdef PIPE_STALL_WATCHDOG_EN
    localparam logic [9:0] WDOG_THRESH = 10'(WDOG_LIMIT);

    logic [9:0] r_wdog_cnt;
    logic [9:0] w_wdog_cnt_next;
    logic       r_wdog;

    always_comb begin
        w_wdog_cnt_next = r_wdog_cnt;
        if ((stall_o == 4'b0000) || flush)
            w_wdog_cnt_next = 10'd0;
        else if (r_wdog_cnt != 10'h3FF)
            w_wdog_cnt_next = r_wdog_cnt + 10'd1;
    end

    // Flag is sticky until reset so software can see a past hang.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdog_cnt <= 10'd0;
            r_wdog     <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_next;
            if (w_wdog_cnt_next >= WDOG_THRESH)
                r_wdog <= 1'b1;
        end
    end

    assign wdog_o = r_wdog;
`else
    logic w_unused_wdog_limit;
    assign w_unused_wdog_limit = ^(10'(WDOG_LIMIT));
    assign wdog_o              = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int          DRAIN   = 3;
    localparam int          WLIM    = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sIf, sId, sEx, sMem;
    logic [31:0] excType;
    logic [31:0] epc;
    logic [3:0]  stallO;
    logic        flushO;
    logic [31:0] newPcO;
    logic [1:0]  stateO;
    logic        wdogO;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR  (EXC_VEC),
        .DRAIN_CYCLES(DRAIN),
        .WDOG_LIMIT  (WLIM)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stallreq_if     (sIf),
        .stallreq_id     (sId),
        .stallreq_ex     (sEx),
        .stallreq_mem    (sMem),
        .exception_type_i(excType),
        .cp0_epc_i       (epc),
        .stall_o         (stallO),
        .flush           (flushO),
        .new_pc_o        (newPcO),
        .ctrl_state_o    (stateO),
        .wdog_o          (wdogO)
    );

    int nVec = 0;
    int nErr = 0;

    // Model: cycles left in the exception-ignore window, whether the previous
    // accepted cycle had a stall request, and length of the current stall run.
    int drainLeft = 0;
    bit stallPrev = 1'b0;
    int stallRun  = 0;
    bit wdogSeen  = 1'b0;

    logic [3:0]  expStall;
    logic        expFlush;
    logic [31:0] expPc;
    logic [1:0]  expState;
    logic        expWdog;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic rn, input logic [3:0] req,
                               input logic [31:0] et, input logic [31:0] ep);
        int top;
        top = 0;
        for (int k = 0; k < 4; k++)
            if (req[k]) top = k + 1;
        expFlush = rn && (et != 32'h0) && (drainLeft == 0);
        expStall = (!rn || expFlush) ? 4'b0000 : 4'((1 << top) - 1);
        expPc    = !expFlush ? 32'h0 : ((et == 32'h0000000E) ? ep : EXC_VEC);
        expState = (drainLeft > 0) ? 2'd2 : (stallPrev ? 2'd1 : 2'd0);
`ifdef PIPE_STALL_WATCHDOG_EN
        expWdog  = wdogSeen;
`else
        expWdog  = 1'b0;
`endif
        compare("stall_o", {28'h0, stallO}, {28'h0, expStall});
        compare("flush", {31'h0, flushO}, {31'h0, expFlush});
        compare("new_pc_o", newPcO, expPc);
        compare("ctrl_state_o", {30'h0, stateO}, {30'h0, expState});
        compare("wdog_o", {31'h0, wdogO}, {31'h0, expWdog});
    endtask

    task automatic updateModel(input logic rn, input logic [3:0] req);
        if (!rn) begin
            drainLeft = 0;
            stallPrev = 1'b0;
            stallRun  = 0;
            wdogSeen  = 1'b0;
        end else begin
            stallRun = (expStall != 4'b0000) ? stallRun + 1 : 0;
            if (stallRun >= WLIM) wdogSeen = 1'b1;
            if (drainLeft > 0) begin
                drainLeft = drainLeft - 1;
                stallPrev = 1'b0;
            end else if (expFlush) begin
                drainLeft = DRAIN;
                stallPrev = 1'b0;
            end else begin
                stallPrev = (req != 4'b0000);
            end
        end
    endtask

    // req bits: {mem, ex, id, if}
    task automatic applyStimulus(input logic rn, input logic [3:0] req,
                                 input logic [31:0] et, input logic [31:0] ep);
        @(negedge clk);
        resetn  = rn;
        sIf     = req[0];
        sId     = req[1];
        sEx     = req[2];
        sMem    = req[3];
        excType = et;
        epc     = ep;
        #1;
        checkOutput(rn, req, et, ep);
        @(posedge clk);
        updateModel(rn, req);
    endtask

    initial begin
        logic [31:0] et;
        logic [3:0]  rq;
        logic        rn;
        resetn  = 1'b0;
        {sIf, sId, sEx, sMem} = 4'b0000;
        excType = 32'h0;
        epc     = 32'h0;

        applyStimulus(1'b0, 4'b1010, 32'h0000000C, 32'h12345678);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);

        // ex stall for three cycles
        applyStimulus(1'b1, 4'b0100, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0100, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0100, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);

        applyStimulus(1'b1, 4'b1010, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);

        // exception under a MEM stall, then the drain window
        applyStimulus(1'b1, 4'b1000, 32'h0000000C, 32'h0);
        applyStimulus(1'b1, 4'b1000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0001, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);

        // ERET, exceptions ignored while draining, accepted once back in RUN
        applyStimulus(1'b1, 4'b0000, 32'h0000000E, 32'hBFC01234);
        applyStimulus(1'b1, 4'b0000, 32'h0000000C, 32'h0);
        applyStimulus(1'b1, 4'b0010, 32'h0000000E, 32'hAAAA5555);
        applyStimulus(1'b1, 4'b0000, 32'h00000004, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h00000008, 32'h0);

        // reset mid-DRAIN and mid-STALL
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'b0100, 32'h0000000C, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0010, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'b0010, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);

        // long IF stall, then release and reset
        for (int i = 0; i < WLIM + 2; i++)
            applyStimulus(1'b1, 4'b0001, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 59) != 0);
            for (int b = 0; b < 4; b++)
                rq[b] = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 11))
                0:       et = 32'h0000000E;
                1:       et = 32'h0000000C;
                2:       et = $urandom() | 32'h1;
                default: et = 32'h0;
            endcase
            applyStimulus(rn, rq, et, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
